// File: rtl/vga_timing_pkg.sv
// Raster timing defaults (640x480@60), colour-field layout and shared types for
// the VGA scan generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 6;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned PIX_LAT_DEF   = 1;

    localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    // Bit positions inside the {R1,R0,G1,G0,B1,B0} colour field.
    localparam int unsigned RGB_R1 = 5;
    localparam int unsigned RGB_R0 = 4;
    localparam int unsigned RGB_G1 = 3;
    localparam int unsigned RGB_G0 = 2;
    localparam int unsigned RGB_B1 = 1;
    localparam int unsigned RGB_B0 = 0;

    localparam logic [RGB_W-1:0] FG_COLOR_DEF = 6'b111111;
    localparam logic [RGB_W-1:0] BG_COLOR_DEF = 6'b000000;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_generator_if.sv
// Scan-position / sync / colour bundle between the scan generator and the
// pixel renderer or display sink.
interface vga_scan_generator_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] horizCounter;
    logic [CNT_W-1:0] vertCounter;
    logic             pixel_bw;
    logic             hsync_n;
    logic             vsync_n;
    logic [RGB_W-1:0] rgb;
    logic             frame_tick;

    modport master (
        output horizCounter, vertCounter, hsync_n, vsync_n, rgb, frame_tick,
        input  pixel_bw
    );

    modport slave (
        input  horizCounter, vertCounter, hsync_n, vsync_n, rgb, frame_tick,
        output pixel_bw
    );

endinterface

// File: rtl/vga_pipe_delay.sv
// Width/depth-parameterised shift register with synchronous clear; depth 0 is
// a combinational pass-through.
module vga_pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ reset;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            // Newest sample enters at index 0; the oldest falls off the top.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= (DEPTH*WIDTH)'({r_stage, i_d});
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_generator.sv
// Free-running raster counters plus sync/colour outputs aligned to the
// renderer's pixel, and a once-per-frame tick at the start of vertical blanking.
module vga_scan_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned      H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned      H_FRONT   = H_FRONT_DEF,
    parameter int unsigned      H_SYNC    = H_SYNC_DEF,
    parameter int unsigned      H_BACK    = H_BACK_DEF,
    parameter int unsigned      V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned      V_FRONT   = V_FRONT_DEF,
    parameter int unsigned      V_SYNC    = V_SYNC_DEF,
    parameter int unsigned      V_BACK    = V_BACK_DEF,
    parameter int unsigned      PIX_LAT   = PIX_LAT_DEF,
    parameter logic [RGB_W-1:0] FG_COLOR  = FG_COLOR_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR  = BG_COLOR_DEF
) (
    input logic                 clk,
    input logic                 reset,
    vga_scan_generator_if.master bus
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    scan_flags_t      w_raw;
    scan_flags_t      w_dly;
    logic             r_hsync_n;
    logic             r_vsync_n;
    logic [RGB_W-1:0] r_rgb;
    logic             r_frame_tick;

    // Next scan position; both counters wrap together on the last pixel of a frame.
    always_comb begin
        w_h_next = r_h + CNT_W'(1);
        w_v_next = r_v;
        if (r_h == CNT_W'(H_TOTAL - 1)) begin
            w_h_next = '0;
            w_v_next = (r_v == CNT_W'(V_TOTAL - 1)) ? '0 : r_v + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h          <= '0;
            r_v          <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_h          <= w_h_next;
            r_v          <= w_v_next;
            r_frame_tick <= (w_h_next == '0) && (w_v_next == CNT_W'(V_VISIBLE));
        end
    end

    // Stage-0 decode of the position currently on the counters.
    always_comb begin
        w_raw        = '0;
        w_raw.active = (r_h < CNT_W'(H_VISIBLE)) && (r_v < CNT_W'(V_VISIBLE));
        w_raw.hs     = in_window(r_h, CNT_W'(HS_START), CNT_W'(HS_END));
        w_raw.vs     = in_window(r_v, CNT_W'(VS_START), CNT_W'(VS_END));
    end

    vga_pipe_delay #(
        .WIDTH ($bits(scan_flags_t)),
        .DEPTH (PIX_LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    // pixel_bw only matters inside the delayed active window, so blanking garbage is masked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_rgb     <= '0;
        end else begin
            r_hsync_n <= ~w_dly.hs;
            r_vsync_n <= ~w_dly.vs;
            r_rgb     <= w_dly.active ? (bus.pixel_bw ? FG_COLOR : BG_COLOR) : '0;
        end
    end

    assign bus.horizCounter = r_h;
    assign bus.vertCounter  = r_v;
    assign bus.hsync_n      = r_hsync_n;
    assign bus.vsync_n      = r_vsync_n;
    assign bus.rgb          = r_rgb;
    assign bus.frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: one default 640x480 instance plus three small-raster
// instances (PIX_LAT 1, 0, 3) checked every cycle against a position-count model.
module tb_vga_scan_generator;
    import vga_timing_pkg::*;

    localparam int NDUT = 4;
    localparam int P_HV [NDUT] = '{640, 16, 16, 16};
    localparam int P_HF [NDUT] = '{16, 4, 4, 4};
    localparam int P_HS [NDUT] = '{96, 6, 6, 6};
    localparam int P_HB [NDUT] = '{48, 4, 4, 4};
    localparam int P_VV [NDUT] = '{480, 12, 12, 12};
    localparam int P_VF [NDUT] = '{10, 2, 2, 2};
    localparam int P_VS [NDUT] = '{2, 2, 2, 2};
    localparam int P_VB [NDUT] = '{33, 3, 3, 3};
    localparam int P_L  [NDUT] = '{1, 1, 0, 3};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_scan_generator_if if0 ();
    vga_scan_generator_if if1 ();
    vga_scan_generator_if if2 ();
    vga_scan_generator_if if3 ();

    vga_scan_generator #(.PIX_LAT(P_L[0])) u_d0 (.clk(clk), .reset(reset), .bus(if0));
    vga_scan_generator #(.H_VISIBLE(P_HV[1]), .H_FRONT(P_HF[1]), .H_SYNC(P_HS[1]), .H_BACK(P_HB[1]),
                         .V_VISIBLE(P_VV[1]), .V_FRONT(P_VF[1]), .V_SYNC(P_VS[1]), .V_BACK(P_VB[1]),
                         .PIX_LAT(P_L[1])) u_d1 (.clk(clk), .reset(reset), .bus(if1));
    vga_scan_generator #(.H_VISIBLE(P_HV[2]), .H_FRONT(P_HF[2]), .H_SYNC(P_HS[2]), .H_BACK(P_HB[2]),
                         .V_VISIBLE(P_VV[2]), .V_FRONT(P_VF[2]), .V_SYNC(P_VS[2]), .V_BACK(P_VB[2]),
                         .PIX_LAT(P_L[2])) u_d2 (.clk(clk), .reset(reset), .bus(if2));
    vga_scan_generator #(.H_VISIBLE(P_HV[3]), .H_FRONT(P_HF[3]), .H_SYNC(P_HS[3]), .H_BACK(P_HB[3]),
                         .V_VISIBLE(P_VV[3]), .V_FRONT(P_VF[3]), .V_SYNC(P_VS[3]), .V_BACK(P_VB[3]),
                         .PIX_LAT(P_L[3])) u_d3 (.clk(clk), .reset(reset), .bus(if3));

    int          total;
    int          bad;
    longint      cyc;
    bit          pix_const;
    longint      n_pos [NDUT];
    logic [9:0]  s_h   [NDUT];
    logic [9:0]  s_v   [NDUT];
    logic        s_hsn [NDUT];
    logic        s_vsn [NDUT];
    logic [5:0]  s_rgb [NDUT];
    logic        s_tick[NDUT];

    function automatic int htot(input int i);
        return P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
    endfunction
    function automatic int vtot(input int i);
        return P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
    endfunction
    function automatic int hpos(input int i, input longint n);
        return int'(n % longint'(htot(i)));
    endfunction
    function automatic int vpos(input int i, input longint n);
        return int'((n / longint'(htot(i))) % longint'(vtot(i)));
    endfunction
    function automatic bit pattern(input int h, input int v);
        return bit'(((h >> 1) ^ v) & 1);
    endfunction

    task automatic chk(input string name, input int i, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, i, cyc, act, exp);
        end
    endtask

    function automatic longint get(input int i, input int which);
        case (which)
            0: return longint'(s_h[i]);
            1: return longint'(s_v[i]);
            2: return longint'(s_hsn[i]);
            3: return longint'(s_vsn[i]);
            4: return longint'(s_rgb[i]);
            default: return longint'(s_tick[i]);
        endcase
    endfunction

    // One clock: predict from the scan position count, drive pixel_bw, then compare everything.
    task automatic step(input bit rst);
        logic       pix   [NDUT];
        longint     n_new [NDUT];
        int         e_h   [NDUT];
        int         e_v   [NDUT];
        bit         e_hsn [NDUT];
        bit         e_vsn [NDUT];
        bit         e_tick[NDUT];
        logic [5:0] e_rgb [NDUT];
        for (int i = 0; i < NDUT; i++) begin
            longint src;
            int     ph;
            int     pv;
            pix[i] = 1'($urandom);
            e_hsn[i] = 1'b1; e_vsn[i] = 1'b1; e_rgb[i] = 6'h00; e_tick[i] = 1'b0;
            if (rst) begin
                n_new[i] = 0; e_h[i] = 0; e_v[i] = 0;
            end else begin
                n_new[i] = n_pos[i] + 1;
                e_h[i] = hpos(i, n_new[i]);
                e_v[i] = vpos(i, n_new[i]);
                e_tick[i] = (e_h[i] == 0) && (e_v[i] == P_VV[i]);
                src = n_new[i] - longint'(P_L[i]) - 1;
                if (src >= 0) begin
                    ph = hpos(i, src);
                    pv = vpos(i, src);
                    e_hsn[i] = !(ph >= P_HV[i] + P_HF[i] && ph < P_HV[i] + P_HF[i] + P_HS[i]);
                    e_vsn[i] = !(pv >= P_VV[i] + P_VF[i] && pv < P_VV[i] + P_VF[i] + P_VS[i]);
                    if (ph < P_HV[i] && pv < P_VV[i]) begin
                        pix[i] = pix_const ? 1'b1 : pattern(ph, pv);
                        e_rgb[i] = pix[i] ? 6'h3f : 6'h00;
                    end
                end
            end
        end
        if0.pixel_bw = pix[0]; if1.pixel_bw = pix[1];
        if2.pixel_bw = pix[2]; if3.pixel_bw = pix[3];
        reset = rst;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        s_h[0] = if0.horizCounter; s_v[0] = if0.vertCounter; s_hsn[0] = if0.hsync_n;
        s_vsn[0] = if0.vsync_n; s_rgb[0] = if0.rgb; s_tick[0] = if0.frame_tick;
        s_h[1] = if1.horizCounter; s_v[1] = if1.vertCounter; s_hsn[1] = if1.hsync_n;
        s_vsn[1] = if1.vsync_n; s_rgb[1] = if1.rgb; s_tick[1] = if1.frame_tick;
        s_h[2] = if2.horizCounter; s_v[2] = if2.vertCounter; s_hsn[2] = if2.hsync_n;
        s_vsn[2] = if2.vsync_n; s_rgb[2] = if2.rgb; s_tick[2] = if2.frame_tick;
        s_h[3] = if3.horizCounter; s_v[3] = if3.vertCounter; s_hsn[3] = if3.hsync_n;
        s_vsn[3] = if3.vsync_n; s_rgb[3] = if3.rgb; s_tick[3] = if3.frame_tick;
        for (int i = 0; i < NDUT; i++) begin
            chk("m_hcnt", i, longint'(s_h[i]), longint'(e_h[i]));
            chk("m_vcnt", i, longint'(s_v[i]), longint'(e_v[i]));
            chk("m_hsync_n", i, longint'(s_hsn[i]), longint'(e_hsn[i]));
            chk("m_vsync_n", i, longint'(s_vsn[i]), longint'(e_vsn[i]));
            chk("m_rgb", i, longint'(s_rgb[i]), longint'(e_rgb[i]));
            chk("m_frame_tick", i, longint'(s_tick[i]), longint'(e_tick[i]));
            n_pos[i] = n_new[i];
        end
    endtask

    // Step until sampled signal 'which' of DUT i equals val; an expired budget is a failure.
    task automatic wait_for(input string name, input int i, input int which,
                            input longint val, input int budget);
        for (int k = 0; k < budget && get(i, which) != val; k++) step(1'b0);
        if (get(i, which) != val) chk({"timeout_", name}, i, get(i, which), val);
    endtask

    task automatic wait_pos(input string name, input int i, input int h, input int v, input int budget);
        for (int k = 0; k < budget && !(s_h[i] == 10'(h) && s_v[i] == 10'(v)); k++) step(1'b0);
        if (!(s_h[i] == 10'(h) && s_v[i] == 10'(v))) chk({"timeout_", name}, i, longint'(s_h[i]), longint'(h));
    endtask

    initial begin
        longint c0;
        longint c1;
        int     exp_lat [NDUT];
        exp_lat = '{2, 2, 1, 4};
        total = 0; bad = 0; cyc = 0; pix_const = 1'b1;
        reset = 1'b1;
        if0.pixel_bw = 1'b0; if1.pixel_bw = 1'b0; if2.pixel_bw = 1'b0; if3.pixel_bw = 1'b0;
        for (int i = 0; i < NDUT; i++) n_pos[i] = 0;
        @(negedge clk);

        repeat (5) step(1'b1);
        chk("rst_hsync_n", 0, longint'(s_hsn[0]), 1);
        chk("rst_vsync_n", 0, longint'(s_vsn[0]), 1);
        chk("rst_rgb", 0, longint'(s_rgb[0]), 0);
        chk("rst_hcnt", 0, longint'(s_h[0]), 0);
        step(1'b0);
        chk("first_h", 0, longint'(s_h[0]), 1);
        chk("first_h", 1, longint'(s_h[1]), 1);

        // Default raster: hsync timing over one line.
        wait_for("line_start", 0, 0, 0, 1000);
        c0 = cyc;
        wait_for("hs_fall", 0, 2, 0, 1000);
        chk("hs_fall_delay", 0, cyc - c0, 658);
        c1 = cyc;
        wait_for("hs_rise", 0, 2, 1, 200);
        chk("hs_low_width", 0, cyc - c1, 96);
        wait_for("hs_fall2", 0, 2, 0, 1000);
        chk("line_period", 0, cyc - c1, 800);

        // Constant white pixel: visible inside active area, masked in blanking.
        wait_pos("pos_5_3", 1, 5, 3, 600);
        step(1'b0); step(1'b0);
        chk("fg_active", 1, longint'(s_rgb[1]), 6'h3f);
        wait_pos("pos_16_3", 1, 16, 3, 600);
        step(1'b0); step(1'b0);
        chk("blank_h", 1, longint'(s_rgb[1]), 0);
        pix_const = 1'b0;

        // Small raster: frame tick position/period and vsync width/alignment.
        wait_for("tick1", 1, 5, 1, 600);
        chk("tick_h", 1, longint'(s_h[1]), 0);
        chk("tick_v", 1, longint'(s_v[1]), 12);
        c0 = cyc;
        step(1'b0);
        wait_for("tick2", 1, 5, 1, 600);
        chk("frame_period", 1, cyc - c0, 570);
        wait_for("vs_fall", 1, 3, 0, 600);
        chk("vs_fall_h", 1, longint'(s_h[1]), 2);
        chk("vs_fall_v", 1, longint'(s_v[1]), 14);
        c1 = cyc;
        wait_for("vs_rise", 1, 3, 1, 100);
        chk("vs_low_width", 1, cyc - c1, 60);

        // Sync-to-counter offset for PIX_LAT 1, 0, 3.
        for (int i = 1; i < NDUT; i++) begin
            wait_for("hs_start", i, 0, 20, 40);
            c0 = cyc;
            wait_for("lat_fall", i, 2, 0, 10);
            chk("sync_offset", i, cyc - c0, longint'(exp_lat[i]));
        end

        // One-clock reset mid-frame.
        wait_pos("pos_7_5", 1, 7, 5, 600);
        step(1'b1);
        chk("midrst_h", 1, longint'(s_h[1]), 0);
        chk("midrst_v", 1, longint'(s_v[1]), 0);
        chk("midrst_hsync_n", 1, longint'(s_hsn[1]), 1);
        chk("midrst_vsync_n", 1, longint'(s_vsn[1]), 1);
        c0 = cyc;
        wait_for("tick_after_rst", 1, 5, 1, 600);
        chk("rst_to_tick", 1, cyc - c0, 360);
        repeat (40) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
